alu_seq: RTL

- Parametrised multi-cycle successor to the single-cycle ALU in the RV32 core.
- Keeps the existing single-cycle ops and their 3-bit encodings, widened to a 4-bit op field.
- Adds RV32M-style multiply/divide, computed iteratively (one bit per cycle) behind a start/done handshake.
- Sits in the execute stage; the control unit stalls the PC while busy is high.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_divider.sv | 71 +++++++
 rtl/alu_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM states and op classification for alu_seq.
// Optional divider datapath: define ALU_SEQ_DIV_EN.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_MULHU = 4'b1001;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_REMU  = 4'b1011;
  localparam logic [3:0] ALU_DIV   = 4'b1100;
  localparam logic [3:0] ALU_REM   = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // True for any divide/remainder code, whether or not the divider is built.
  function automatic logic is_div(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  // Ops that take the iterative CALC/FIX path.
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == ALU_MUL) || (op == ALU_MULHU) || is_div(op);
`else
    return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring divider, one quotient bit per step, with signed result fix-up.
// Instantiated by alu_seq only when ALU_SEQ_DIV_EN is defined.
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot_c,
  output logic [WIDTH-1:0] o_rem_c
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Operand magnitudes; the most-negative value maps to itself, read as unsigned.
  assign w_a_neg = i_signed && i_dividend[WIDTH-1];
  assign w_b_neg = i_signed && i_divisor[WIDTH-1];
  assign w_abs_a = w_a_neg ? (~i_dividend + WIDTH'(1)) : i_dividend;
  assign w_abs_b = w_b_neg ? (~i_divisor + WIDTH'(1)) : i_divisor;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  // Load magnitudes and sign flags, then shift-subtract once per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_quo   <= w_abs_a;
      r_rem   <= '0;
      r_dvs   <= w_abs_b;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (i_step) begin
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Quotient negated on sign mismatch; remainder follows the dividend.
  assign o_quot_c = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
  assign o_rem_c  = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle RV32 ops plus iterative MUL/MULHU and,
// when ALU_SEQ_DIV_EN is defined, DIV/DIVU/REM/REMU via alu_seq_divider.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t             r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic               w_multi;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_fix;
  logic [WIDTH:0]     w_mul_sum;

  // Divide by zero is resolved in one cycle and never iterates.
  assign w_multi = is_multicycle(ALUControl) && !(is_div(ALUControl) && (srcB == '0));

  // Single-cycle results, taken from the live inputs on the accepting edge.
  always_comb begin
    w_alu = '0;
    case (ALUControl)
      ALU_ADD:  w_alu = srcA + srcB;
      ALU_SUB:  w_alu = srcA - srcB;
      ALU_AND:  w_alu = srcA & srcB;
      ALU_OR:   w_alu = srcA | srcB;
      ALU_XOR:  w_alu = srcA ^ srcB;
      ALU_SLT:  w_alu = WIDTH'($signed(srcA) < $signed(srcB));
      ALU_SLTU: w_alu = WIDTH'(srcA < srcB);
`ifdef ALU_SEQ_DIV_EN
      ALU_DIVU, ALU_DIV: w_alu = '1;
      ALU_REMU, ALU_REM: w_alu = srcA;
`endif
      default:  w_alu = '0;
    endcase
  end

  // Shift-add step: conditionally add multiplicand to the upper half.
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

`ifdef ALU_SEQ_DIV_EN
  logic             w_div_load;
  logic             w_div_step;
  logic             w_div_signed;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_div_load   = (r_state == ST_IDLE) && start && w_multi && is_div(ALUControl);
  assign w_div_step   = (r_state == ST_CALC) && is_div(r_op);
  assign w_div_signed = (ALUControl == ALU_DIV) || (ALUControl == ALU_REM);

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_signed   (w_div_signed),
    .i_dividend (srcA),
    .i_divisor  (srcB),
    .o_quot_c   (w_quot),
    .o_rem_c    (w_rem)
  );
`endif

  // Final result selection for the iterative ops.
  always_comb begin
    w_fix = '0;
    case (r_op)
      ALU_MUL:   w_fix = r_prod[WIDTH-1:0];
      ALU_MULHU: w_fix = r_prod[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
      ALU_DIVU, ALU_DIV: w_fix = w_quot;
      ALU_REMU, ALU_REM: w_fix = w_rem;
`endif
      default:   w_fix = '0;
    endcase
  end

  // Control FSM with the multiplier datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op <= ALUControl;
            if (w_multi) begin
              r_mcand <= srcA;
              r_prod  <= {WIDTH'(0), srcB};
              r_cnt   <= CNT_W'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end else begin
              r_result <= w_alu;
              r_done   <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_result <= w_fix;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
